// File: rtl/thread_pkg.sv
// thread_pkg: shared defaults, width helpers and lane packing helpers for the thread pipeline
package thread_pkg;

   localparam int NUM_THREADS_DEF = 4;
   localparam int LANES_DEF       = 4;
   localparam int ISN_WIDTH_DEF   = 99;

   // ceil(log2(v)); 0 for v <= 1
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // thread-id width, never narrower than one bit
   function automatic int tid_w(input int n);
      return (clog2(n) > 1) ? clog2(n) : 1;
   endfunction

   localparam int TID_W_DEF = tid_w(NUM_THREADS_DEF);

   // bit offset of lane l in a bundle packed with lane 0 in the MSBs
   function automatic int lane_lsb(input int l, input int lanes, input int isn_w);
      return (lanes - 1 - l) * isn_w;
   endfunction

   // bit offset of thread t's slice in a per-thread flattened bus
   function automatic int thread_lsb(input int t, input int slice_w);
      return t * slice_w;
   endfunction

endpackage

// File: rtl/bundle_fifo.sv
// bundle_fifo: single-thread first-word-fall-through bundle FIFO with flush
module bundle_fifo
   import thread_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CW    = clog2(DEPTH + 1),
   localparam int PW    = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Push,
   input  logic             i_Pop,
   input  logic             i_Flush,
   input  logic [WIDTH-1:0] i_Data,
   output logic [WIDTH-1:0] o_Data,
   output logic [CW-1:0]    o_Count,
   output logic             o_Full,
   output logic             o_Empty
);

   logic [WIDTH-1:0] r_Mem [DEPTH];
   logic [PW-1:0]    r_Wr;
   logic [PW-1:0]    r_Rd;
   logic [CW-1:0]    r_Count;
   logic             w_Push;
   logic             w_Pop;

   // pointers wrap at DEPTH so non-power-of-two depths work
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // full and empty come from the registered count only, so a full FIFO never passes through
   assign o_Full  = (r_Count == CW'(DEPTH));
   assign o_Empty = (r_Count == '0);
   assign o_Count = r_Count;
   assign w_Push  = i_Push && !o_Full && !i_Flush;
   assign w_Pop   = i_Pop && !o_Empty && !i_Flush;
   assign o_Data  = o_Empty ? '0 : r_Mem[r_Rd];

   // pointer and occupancy state; flush clears everything and overrides push/pop
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_Wr    <= '0;
         r_Rd    <= '0;
         r_Count <= '0;
      end else if (i_Flush) begin
         r_Wr    <= '0;
         r_Rd    <= '0;
         r_Count <= '0;
      end else begin
         if (w_Push) r_Wr <= next_ptr(r_Wr);
         if (w_Pop) r_Rd <= next_ptr(r_Rd);
         r_Count <= r_Count + CW'(w_Push) - CW'(w_Pop);
      end
   end

   // entry storage; contents are masked by o_Empty so they need no reset
   always_ff @(posedge i_Clk) begin
      if (w_Push) r_Mem[r_Wr] <= i_Data;
   end

endmodule

// File: rtl/thread_demux_buf.sv
// thread_demux_buf: routes fetch bundles into per-thread FWFT FIFOs with flush and bad-thread detection
module thread_demux_buf
   import thread_pkg::*;
#(
   parameter  int ISN_WIDTH   = ISN_WIDTH_DEF,
   parameter  int LANES       = LANES_DEF,
   parameter  int NUM_THREADS = NUM_THREADS_DEF,
   parameter  int DEPTH       = 2,
   parameter  int DROP_EMPTY  = 1,
   localparam int TID_W       = tid_w(NUM_THREADS)
) (
   input  logic                                   i_Clk,
   input  logic                                   i_Reset,
   input  logic                                   i_Valid,
   input  logic [TID_W-1:0]                       i_Thread,
   input  logic [LANES-1:0]                       i_Lane_Valid,
   input  logic [LANES*ISN_WIDTH-1:0]             i_Bundle,
   output logic [NUM_THREADS-1:0]                 o_Thread_Ready,
   input  logic [NUM_THREADS-1:0]                 i_Flush,
   output logic [NUM_THREADS-1:0]                 o_Valid,
   output logic [NUM_THREADS*LANES-1:0]           o_Lane_Valid,
   output logic [NUM_THREADS*LANES*ISN_WIDTH-1:0] o_Bundle,
   input  logic [NUM_THREADS-1:0]                 i_Ready,
   output logic                                   o_Bad_Thread
);

   localparam int BW = LANES * ISN_WIDTH;
   localparam int EW = LANES * (ISN_WIDTH + 1);
   localparam int CW = clog2(DEPTH + 1);

   logic                            w_In_Range;
   logic                            w_Drop;
   logic [NUM_THREADS-1:0]          w_Full;
   logic [NUM_THREADS-1:0]          w_Empty;
   logic [NUM_THREADS-1:0][CW-1:0]  w_Count;
   logic                            w_unused_count;
   logic                            r_Bad_Thread;

   // out-of-range ids are swallowed; empty bundles are swallowed only when DROP_EMPTY is set
   assign w_In_Range     = 32'(i_Thread) < NUM_THREADS;
   assign w_Drop         = (DROP_EMPTY != 0) && (i_Lane_Valid == '0);
   assign o_Thread_Ready = ~w_Full;
   assign o_Valid        = ~w_Empty;
   assign o_Bad_Thread   = r_Bad_Thread;
   assign w_unused_count = ^w_Count;

   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
      logic          w_Push;
      logic [EW-1:0] w_Head;

      assign w_Push = i_Valid && w_In_Range && (i_Thread == TID_W'(t)) && !w_Drop;

      bundle_fifo #(
         .WIDTH (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .i_Clk   (i_Clk),
         .i_Reset (i_Reset),
         .i_Push  (w_Push),
         .i_Pop   (i_Ready[t]),
         .i_Flush (i_Flush[t]),
         .i_Data  ({i_Lane_Valid, i_Bundle}),
         .o_Data  (w_Head),
         .o_Count (w_Count[t]),
         .o_Full  (w_Full[t]),
         .o_Empty (w_Empty[t])
      );

      assign o_Lane_Valid[thread_lsb(t, LANES) +: LANES] = w_Head[EW-1 -: LANES];
      assign o_Bundle[thread_lsb(t, BW) +: BW]           = w_Head[BW-1:0];
   end

   // one-cycle pulse for each cycle a bundle to a nonexistent thread is consumed
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) r_Bad_Thread <= 1'b0;
      else         r_Bad_Thread <= i_Valid && !w_In_Range;
   end

endmodule

// File: tb/tb_thread_demux_buf.sv
// tb_thread_demux_buf: table-driven and scoreboard checks of the per-thread bundle demux
module tb_thread_demux_buf;

   localparam int DEPTH = 2;
   localparam int BW    = 396;

   typedef logic [399:0] ent_t;

   typedef struct {
      logic       v;
      logic [1:0] th;
      logic [3:0] ln;
      int         sd;
      logic [3:0] rd;
      logic [3:0] fl;
      logic [3:0] ev;
      logic [3:0] er;
   } vec_t;

   logic          clk, rst;
   logic          valid;
   logic [1:0]    thread;
   logic [3:0]    lanes;
   logic [BW-1:0] bundle;
   logic [3:0]    ready, flush;
   logic [3:0]    tr, ov;
   logic [15:0]   olv;
   logic [4*BW-1:0] ob;
   logic          bad;

   logic          v3;
   logic [1:0]    th3;
   logic [1:0]    ln3;
   logic [15:0]   b3;
   logic [2:0]    rd3, fl3, tr3, ov3;
   logic [5:0]    olv3;
   logic [47:0]   ob3;
   logic          bad3;

   int   checks = 0;
   int   fails  = 0;
   ent_t q [4][$];
   vec_t tbl [32];

   thread_demux_buf #(.ISN_WIDTH(99), .LANES(4), .NUM_THREADS(4), .DEPTH(DEPTH), .DROP_EMPTY(1)) u_dut (
      .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Thread(thread), .i_Lane_Valid(lanes),
      .i_Bundle(bundle), .o_Thread_Ready(tr), .i_Flush(flush), .o_Valid(ov), .o_Lane_Valid(olv),
      .o_Bundle(ob), .i_Ready(ready), .o_Bad_Thread(bad));

   thread_demux_buf #(.ISN_WIDTH(8), .LANES(2), .NUM_THREADS(3), .DEPTH(2), .DROP_EMPTY(0)) u_dut3 (
      .i_Clk(clk), .i_Reset(rst), .i_Valid(v3), .i_Thread(th3), .i_Lane_Valid(ln3),
      .i_Bundle(b3), .o_Thread_Ready(tr3), .i_Flush(fl3), .o_Valid(ov3), .o_Lane_Valid(olv3),
      .o_Bundle(ob3), .i_Ready(rd3), .o_Bad_Thread(bad3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pat(input int s);
      logic [415:0] w;
      for (int i = 0; i < 13; i++) w[i*32 +: 32] = (32'(s) * 32'h9E3779B1) ^ (32'(i) << 8) ^ 32'(s);
      return w[BW-1:0];
   endfunction

   function automatic vec_t mk(input logic v, input logic [1:0] th, input logic [3:0] ln, input int sd,
                               input logic [3:0] rd, input logic [3:0] fl, input logic [3:0] ev,
                               input logic [3:0] er);
      vec_t e;
      e.v = v; e.th = th; e.ln = ln; e.sd = sd; e.rd = rd; e.fl = fl; e.ev = ev; e.er = er;
      return e;
   endfunction

   // scoreboard: compare heads against the queues, then apply this cycle's handshakes to them
   always @(negedge clk) begin
      if (rst) begin
         for (int t = 0; t < 4; t++) q[t].delete();
      end else begin : mon
         logic [3:0] ev, er;
         logic       psh;
         ent_t       exp_e;
         for (int t = 0; t < 4; t++) begin
            ev[t] = q[t].size() != 0;
            er[t] = q[t].size() < DEPTH;
            exp_e = ev[t] ? q[t][0] : '0;
            chk($sformatf("head%0d", t), {olv[t*4 +: 4], ob[t*BW +: BW]}, exp_e);
         end
         chk("sb_valid", 400'(ov), 400'(ev));
         chk("sb_ready", 400'(tr), 400'(er));
         psh = valid && er[thread] && (lanes != 4'h0);
         for (int t = 0; t < 4; t++) begin
            if (flush[t]) q[t].delete();
            else begin
               if (ev[t] && ready[t]) void'(q[t].pop_front());
               if (psh && thread == 2'(t)) q[t].push_back({lanes, bundle});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; valid = 1'b0; thread = '0; lanes = '0; bundle = '0; ready = '0; flush = '0;
      v3 = 1'b0; th3 = '0; ln3 = '0; b3 = '0; rd3 = '0; fl3 = '0;
      tbl[0]  = mk(1'b1, 2'd2, 4'hF, 1,  4'h0, 4'h0, 4'h4, 4'hF);
      tbl[1]  = mk(1'b0, 2'd0, 4'h0, 0,  4'h4, 4'h0, 4'h0, 4'hF);
      tbl[2]  = mk(1'b1, 2'd1, 4'hF, 2,  4'h0, 4'h0, 4'h2, 4'hF);
      tbl[3]  = mk(1'b1, 2'd1, 4'h3, 3,  4'h0, 4'h0, 4'h2, 4'hD);
      tbl[4]  = mk(1'b1, 2'd1, 4'hA, 4,  4'h0, 4'h0, 4'h2, 4'hD);
      tbl[5]  = mk(1'b1, 2'd1, 4'hA, 4,  4'h2, 4'h0, 4'h2, 4'hF);
      tbl[6]  = mk(1'b1, 2'd1, 4'hA, 4,  4'h0, 4'h0, 4'h2, 4'hD);
      tbl[7]  = mk(1'b0, 2'd0, 4'h0, 0,  4'h2, 4'h0, 4'h2, 4'hF);
      tbl[8]  = mk(1'b0, 2'd0, 4'h0, 0,  4'h2, 4'h0, 4'h0, 4'hF);
      tbl[9]  = mk(1'b1, 2'd0, 4'hF, 5,  4'h0, 4'h0, 4'h1, 4'hF);
      tbl[10] = mk(1'b1, 2'd0, 4'h4, 6,  4'h0, 4'h0, 4'h1, 4'hE);
      tbl[11] = mk(1'b1, 2'd0, 4'hF, 7,  4'h1, 4'h0, 4'h1, 4'hF);
      tbl[12] = mk(1'b1, 2'd0, 4'hF, 7,  4'h0, 4'h0, 4'h1, 4'hE);
      tbl[13] = mk(1'b0, 2'd0, 4'h0, 0,  4'h1, 4'h0, 4'h1, 4'hF);
      tbl[14] = mk(1'b1, 2'd3, 4'hF, 8,  4'h0, 4'h0, 4'h9, 4'hF);
      tbl[15] = mk(1'b1, 2'd3, 4'h6, 9,  4'h0, 4'h0, 4'h9, 4'h7);
      tbl[16] = mk(1'b1, 2'd3, 4'hF, 10, 4'h0, 4'h8, 4'h1, 4'hF);
      tbl[17] = mk(1'b1, 2'd3, 4'hF, 11, 4'h0, 4'h0, 4'h9, 4'hF);
      tbl[18] = mk(1'b1, 2'd3, 4'hF, 12, 4'h0, 4'h8, 4'h1, 4'hF);
      tbl[19] = mk(1'b1, 2'd1, 4'h1, 13, 4'h0, 4'h0, 4'h3, 4'hF);
      tbl[20] = mk(1'b0, 2'd0, 4'h0, 0,  4'h1, 4'h3, 4'h0, 4'hF);
      tbl[21] = mk(1'b1, 2'd2, 4'h0, 14, 4'h0, 4'h0, 4'h0, 4'hF);
      tbl[22] = mk(1'b1, 2'd2, 4'hF, 15, 4'h4, 4'h0, 4'h4, 4'hF);
      tbl[23] = mk(1'b1, 2'd2, 4'h5, 16, 4'h4, 4'h0, 4'h4, 4'hF);
      tbl[24] = mk(1'b1, 2'd0, 4'hF, 17, 4'h0, 4'h0, 4'h5, 4'hF);
      tbl[25] = mk(1'b1, 2'd1, 4'hF, 18, 4'h0, 4'h0, 4'h7, 4'hF);
      tbl[26] = mk(1'b1, 2'd3, 4'hF, 19, 4'h0, 4'h0, 4'hF, 4'hF);
      tbl[27] = mk(1'b0, 2'd0, 4'h0, 0,  4'hF, 4'h0, 4'h0, 4'hF);
      tbl[28] = mk(1'b1, 2'd0, 4'hF, 20, 4'h0, 4'h0, 4'h1, 4'hF);
      tbl[29] = mk(1'b1, 2'd1, 4'h8, 21, 4'h0, 4'h0, 4'h3, 4'hF);
      tbl[30] = mk(1'b1, 2'd2, 4'hF, 22, 4'h0, 4'h0, 4'h7, 4'hF);
      tbl[31] = mk(1'b1, 2'd3, 4'h2, 23, 4'h0, 4'h0, 4'hF, 4'hF);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 400'(ov), 400'(0));
      chk("rst_ready", 400'(tr), 400'(4'hF));
      chk("rst_data", 400'(|ob || |olv), 400'(0));
      chk("rst_bad", 400'(bad), 400'(0));
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         valid = tbl[i].v; thread = tbl[i].th; lanes = tbl[i].ln;
         bundle = pat(tbl[i].sd); ready = tbl[i].rd; flush = tbl[i].fl;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), 400'(ov), 400'(tbl[i].ev));
         chk($sformatf("vec%0d_ready", i), 400'(tr), 400'(tbl[i].er));
      end

      valid = 1'b0; ready = '0; flush = '0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 400'(ov), 400'(0));
      chk("async_rst_ready", 400'(tr), 400'(4'hF));
      chk("async_rst_data", 400'(|ob || |olv), 400'(0));
      chk("async_rst_bad", 400'(bad), 400'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_valid", 400'(ov), 400'(0));

      v3 = 1'b1; th3 = 2'd3; ln3 = 2'b11; b3 = 16'h1234;
      @(posedge clk);
      #1 v3 = 1'b0;
      chk("bad_pulse", 400'(bad3), 400'(1));
      chk("bad_nostore", 400'(ov3), 400'(0));
      @(posedge clk);
      #1;
      chk("bad_one_cycle", 400'(bad3), 400'(0));

      v3 = 1'b1; th3 = 2'd0; ln3 = 2'b00; b3 = 16'hBEEF;
      @(posedge clk);
      #1 v3 = 1'b0;
      chk("keep_empty_valid", 400'(ov3), 400'(3'b001));
      chk("keep_empty_lanes", 400'(olv3), 400'(0));
      chk("keep_empty_data", 400'(ob3), 400'(48'hBEEF));
      chk("keep_empty_ready", 400'(tr3), 400'(3'b111));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
